// File: rtl/i2c_slave_regs.sv
// I2C target exposing a byte-addressed register window to a host-side register port.
// SCL is input only (no clock stretching); SDA is open-drain through sda_o/sda_t.
module i2c_slave_regs #(
  parameter logic [6:0]  DEV_ADDR  = 7'h50,
  parameter int unsigned PTR_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 enable,
  input  logic                 scl_i,
  input  logic                 sda_i,
  output logic                 sda_o,
  output logic                 sda_t,
  output logic [PTR_WIDTH-1:0] reg_addr,
  output logic [7:0]           reg_wdata,
  output logic                 reg_we,
  output logic                 reg_rd,
  input  logic [7:0]           reg_rdata,
  output logic                 busy,
  output logic                 bus_active
);

  typedef enum logic [3:0] {
    S_IDLE, S_ADDR, S_ADDR_ACK, S_PTR, S_PTR_ACK,
    S_WDATA, S_WDATA_ACK, S_RDATA, S_RDATA_ACK, S_WAIT
  } state_t;

  state_t               state, state_nxt;
  logic                 scl_m, scl_s, scl_q;
  logic                 sda_m, sda_s, sda_q;
  logic                 scl_rise, scl_fall, start_ev, stop_ev;
  logic [2:0]           cnt, cnt_nxt;
  logic [7:0]           sr, sr_nxt;
  logic                 full, full_nxt;
  logic [7:0]           byte_in;
  logic                 last_bit, addr_hit;
  logic                 sda_t_nxt, reg_we_nxt, reg_rd_nxt, busy_nxt, bus_active_nxt;
  logic [PTR_WIDTH-1:0] reg_addr_nxt;
  logic [7:0]           reg_wdata_nxt;

  assign sda_o = 1'b0;

  // Two-flop synchronisers plus one compare stage for edge detection
  always_ff @(posedge clk) begin
    if (rst) begin
      scl_m <= 1'b1; scl_s <= 1'b1; scl_q <= 1'b1;
      sda_m <= 1'b1; sda_s <= 1'b1; sda_q <= 1'b1;
    end else begin
      scl_m <= scl_i; scl_s <= scl_m; scl_q <= scl_s;
      sda_m <= sda_i; sda_s <= sda_m; sda_q <= sda_s;
    end
  end

  assign scl_rise = scl_s & ~scl_q;
  assign scl_fall = ~scl_s & scl_q;
  assign start_ev = scl_s & scl_q & sda_q & ~sda_s;
  assign stop_ev  = scl_s & scl_q & ~sda_q & sda_s;
  assign byte_in  = {sr[6:0], sda_s};
  assign last_bit = (cnt == 3'd7);
  assign addr_hit = enable && (byte_in[7:1] == DEV_ADDR);

  // State register and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      cnt        <= '0;
      sr         <= '0;
      full       <= 1'b0;
      sda_t      <= 1'b1;
      reg_addr   <= '0;
      reg_wdata  <= '0;
      reg_we     <= 1'b0;
      reg_rd     <= 1'b0;
      busy       <= 1'b0;
      bus_active <= 1'b0;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      sr         <= sr_nxt;
      full       <= full_nxt;
      sda_t      <= sda_t_nxt;
      reg_addr   <= reg_addr_nxt;
      reg_wdata  <= reg_wdata_nxt;
      reg_we     <= reg_we_nxt;
      reg_rd     <= reg_rd_nxt;
      busy       <= busy_nxt;
      bus_active <= bus_active_nxt;
    end
  end

  // Next-state decode; START and STOP override every state
  always_comb begin
    state_nxt = state;
    if (start_ev) begin
      state_nxt = S_ADDR;
    end else if (stop_ev) begin
      state_nxt = S_IDLE;
    end else begin
      case (state)
        S_ADDR: begin
          if (scl_rise && last_bit && !addr_hit) state_nxt = S_WAIT;
          else if (scl_fall && full)             state_nxt = S_ADDR_ACK;
        end
        S_ADDR_ACK:  if (scl_fall) state_nxt = sr[0] ? S_RDATA : S_PTR;
        S_PTR:       if (scl_fall && full) state_nxt = S_PTR_ACK;
        S_PTR_ACK:   if (scl_fall) state_nxt = S_WDATA;
        S_WDATA:     if (scl_fall && full) state_nxt = S_WDATA_ACK;
        S_WDATA_ACK: if (scl_fall) state_nxt = S_WDATA;
        S_RDATA:     if (scl_fall && last_bit) state_nxt = S_RDATA_ACK;
        S_RDATA_ACK: if (scl_fall) state_nxt = sr[0] ? S_WAIT : S_RDATA;
        default:     state_nxt = state;
      endcase
    end
  end

  // Next values of the shift/count datapath and all registered outputs
  always_comb begin
    cnt_nxt        = cnt;
    sr_nxt         = sr;
    full_nxt       = full;
    sda_t_nxt      = sda_t;
    reg_addr_nxt   = reg_addr;
    reg_wdata_nxt  = reg_wdata;
    reg_we_nxt     = 1'b0;
    reg_rd_nxt     = 1'b0;
    busy_nxt       = busy;
    bus_active_nxt = bus_active;
    if (start_ev) begin
      cnt_nxt        = '0;
      full_nxt       = 1'b0;
      sda_t_nxt      = 1'b1;
      bus_active_nxt = 1'b1;
    end else if (stop_ev) begin
      cnt_nxt        = '0;
      full_nxt       = 1'b0;
      sda_t_nxt      = 1'b1;
      busy_nxt       = 1'b0;
      bus_active_nxt = 1'b0;
    end else begin
      // Host data is valid in the reg_rd cycle: capture it and drive its MSB
      if (reg_rd) begin
        sr_nxt    = reg_rdata;
        sda_t_nxt = reg_rdata[7];
      end
      case (state)
        S_ADDR, S_PTR, S_WDATA: begin
          if (scl_rise) begin
            sr_nxt  = byte_in;
            cnt_nxt = cnt + 3'd1;
            if (last_bit) begin
              full_nxt = 1'b1;
              if (state == S_ADDR && !addr_hit) busy_nxt = 1'b0;
              if (state == S_PTR) reg_addr_nxt = PTR_WIDTH'(byte_in);
              if (state == S_WDATA) begin
                reg_wdata_nxt = byte_in;
                reg_we_nxt    = 1'b1;
              end
            end
          end else if (scl_fall && full) begin
            full_nxt  = 1'b0;
            sda_t_nxt = 1'b0;
            if (state == S_ADDR)  busy_nxt = 1'b1;
            if (state == S_WDATA) reg_addr_nxt = reg_addr + PTR_WIDTH'(1);
          end
        end
        S_ADDR_ACK: begin
          if (scl_fall) begin
            cnt_nxt = '0;
            if (sr[0]) reg_rd_nxt = 1'b1;
            else       sda_t_nxt  = 1'b1;
          end
        end
        S_PTR_ACK, S_WDATA_ACK: begin
          if (scl_fall) begin
            cnt_nxt   = '0;
            sda_t_nxt = 1'b1;
          end
        end
        S_RDATA: begin
          if (scl_fall) begin
            if (last_bit) begin
              sda_t_nxt    = 1'b1;
              reg_addr_nxt = reg_addr + PTR_WIDTH'(1);
            end else begin
              sr_nxt    = {sr[6:0], 1'b0};
              sda_t_nxt = sr[6];
              cnt_nxt   = cnt + 3'd1;
            end
          end
        end
        S_RDATA_ACK: begin
          if (scl_rise) begin
            sr_nxt = byte_in;
          end else if (scl_fall) begin
            cnt_nxt = '0;
            if (sr[0]) busy_nxt   = 1'b0;
            else       reg_rd_nxt = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_i2c_slave_regs.sv
// Bench for i2c_slave_regs: acts as the I2C controller and the host register file,
// and compares against a transaction-level model (pointer + register array).
module tb_i2c_slave_regs;

  localparam int unsigned QTR = 8;

  logic        clk = 1'b0;
  logic        rst, enable, scl, m_sda, fill;
  logic        sda_o, sda_t, reg_we, reg_rd, busy, bus_active;
  logic [7:0]  reg_addr, reg_wdata, reg_rdata;
  logic        sda_line;
  logic [7:0]  host_mem [256];
  logic [7:0]  ref_mem  [256];
  logic [7:0]  ptr;
  logic [15:0] exp_wr[$], got_wr[$];
  logic [7:0]  exp_rd[$], got_rd[$];
  int          wr_base = 0, rd_base = 0;
  int          total = 0, bad = 0;
  int          overlap = 0, hi_chg = 0, drove_low = 0, busy_seen = 0;
  logic        sda_t_q = 1'b1;

  always #5 clk = ~clk;

  // Wired-AND bus: controller side and target side
  assign sda_line  = m_sda & (sda_t ? 1'b1 : sda_o);
  assign reg_rdata = host_mem[reg_addr];

  i2c_slave_regs #(.DEV_ADDR(7'h50), .PTR_WIDTH(8)) dut (
    .clk(clk), .rst(rst), .enable(enable), .scl_i(scl), .sda_i(sda_line),
    .sda_o(sda_o), .sda_t(sda_t), .reg_addr(reg_addr), .reg_wdata(reg_wdata),
    .reg_we(reg_we), .reg_rd(reg_rd), .reg_rdata(reg_rdata),
    .busy(busy), .bus_active(bus_active)
  );

  function automatic logic [7:0] init_val(input logic [7:0] a);
    case (a)
      8'h20:   return 8'h5A;
      8'h21:   return 8'hC3;
      8'h40:   return 8'h0F;
      default: return 8'(a * 8'd37 + 8'd91);
    endcase
  endfunction

  // Host register file plus strobe/SDA monitors
  always @(negedge clk) begin
    if (fill) begin
      for (int i = 0; i < 256; i++) host_mem[i] <= init_val(8'(i));
    end else if (reg_we) begin
      host_mem[reg_addr] <= reg_wdata;
    end
    if (reg_we) got_wr.push_back({reg_addr, reg_wdata});
    if (reg_rd) got_rd.push_back(reg_addr);
    if (reg_we && reg_rd) overlap++;
    if (!rst && scl && (sda_t !== sda_t_q)) hi_chg++;
    if (sda_t === 1'b0) drove_low++;
    if (busy === 1'b1) busy_seen++;
    sda_t_q <= sda_t;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h want=0x%0h", tag, got, exp);
    end
  endtask

  task automatic check_queues(input string tag);
    check_eq({tag, "_we_count"}, 32'(got_wr.size() - wr_base), 32'(exp_wr.size()));
    for (int i = 0; i < exp_wr.size(); i++)
      if (wr_base + i < got_wr.size())
        check_eq({tag, "_we_addr_data"}, 32'(got_wr[wr_base + i]), 32'(exp_wr[i]));
    check_eq({tag, "_rd_count"}, 32'(got_rd.size() - rd_base), 32'(exp_rd.size()));
    for (int i = 0; i < exp_rd.size(); i++)
      if (rd_base + i < got_rd.size())
        check_eq({tag, "_rd_addr"}, 32'(got_rd[rd_base + i]), 32'(exp_rd[i]));
    wr_base = got_wr.size();
    rd_base = got_rd.size();
    exp_wr.delete();
    exp_rd.delete();
  endtask

  task automatic qtr();
    repeat (QTR) @(negedge clk);
  endtask

  task automatic bus_start();
    m_sda = 1'b1; qtr(); scl = 1'b1; qtr(); m_sda = 1'b0; qtr(); scl = 1'b0; qtr();
  endtask

  task automatic bus_stop();
    m_sda = 1'b0; qtr(); scl = 1'b1; qtr(); m_sda = 1'b1; qtr();
  endtask

  task automatic clock_bit(input logic b, output logic seen);
    m_sda = b; qtr(); scl = 1'b1; qtr(); seen = sda_line; qtr(); scl = 1'b0; qtr();
  endtask

  task automatic send_byte(input logic [7:0] b, output logic ack);
    logic s;
    for (int i = 7; i >= 0; i--) clock_bit(b[i], s);
    clock_bit(1'b1, s);
    ack = ~s;
  endtask

  task automatic recv_byte(input logic nack, output logic [7:0] b);
    logic s;
    b = '0;
    for (int i = 0; i < 8; i++) begin
      clock_bit(1'b1, s);
      b = {b[6:0], s};
    end
    clock_bit(nack, s);
  endtask

  // Write transaction: address, pointer, n data bytes (taken MSB-first from data)
  task automatic do_write(input logic [6:0] dev, input logic [7:0] p, input int n,
                          input logic [23:0] data);
    logic       ack, match;
    logic [7:0] d;
    match = (dev == 7'h50) && enable;
    bus_start();
    check_eq("start_bus_active", 32'(bus_active), 32'd1);
    send_byte({dev, 1'b0}, ack);
    check_eq("wr_addr_ack", 32'(ack), 32'(match));
    check_eq("wr_busy", 32'(busy), 32'(match));
    send_byte(p, ack);
    check_eq("wr_ptr_ack", 32'(ack), 32'(match));
    if (match) ptr = p;
    for (int k = 0; k < n; k++) begin
      d = data[8*(2-k) +: 8];
      send_byte(d, ack);
      check_eq("wr_data_ack", 32'(ack), 32'(match));
      if (match) begin
        exp_wr.push_back({ptr, d});
        ref_mem[ptr] = d;
        ptr++;
      end
    end
    bus_stop();
    check_eq("wr_end_busy", 32'(busy), 32'd0);
    check_eq("wr_end_bus_active", 32'(bus_active), 32'd0);
    check_queues("wr");
  endtask

  // Read transaction, optionally preceded by a pointer write and repeated START
  task automatic do_read(input logic set_ptr, input logic [7:0] p, input int n);
    logic       ack;
    logic [7:0] b;
    if (set_ptr) begin
      bus_start();
      send_byte(8'hA0, ack);
      check_eq("rd_waddr_ack", 32'(ack), 32'd1);
      send_byte(p, ack);
      check_eq("rd_ptr_ack", 32'(ack), 32'd1);
      ptr = p;
    end
    bus_start();
    send_byte(8'hA1, ack);
    check_eq("rd_addr_ack", 32'(ack), 32'd1);
    for (int k = 0; k < n; k++) begin
      recv_byte(k == n - 1, b);
      check_eq("rd_data", 32'(b), 32'(ref_mem[ptr]));
      exp_rd.push_back(ptr);
      ptr++;
    end
    bus_stop();
    check_eq("rd_end_busy", 32'(busy), 32'd0);
    check_eq("rd_end_bus_active", 32'(bus_active), 32'd0);
    check_queues("rd");
  endtask

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation did not finish, want=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic       ack, s;
    logic [7:0] abyte;
    logic [6:0] dev;
    int         base_low, base_busy;

    rst = 1'b1; fill = 1'b1; enable = 1'b1; scl = 1'b1; m_sda = 1'b1;
    for (int i = 0; i < 256; i++) ref_mem[i] = init_val(8'(i));
    ptr = 8'h00;
    repeat (4) @(negedge clk);
    check_eq("rst_sda_t", 32'(sda_t), 32'd1);
    check_eq("rst_sda_o", 32'(sda_o), 32'd0);
    check_eq("rst_reg_we", 32'(reg_we), 32'd0);
    check_eq("rst_reg_rd", 32'(reg_rd), 32'd0);
    check_eq("rst_reg_addr", 32'(reg_addr), 32'd0);
    check_eq("rst_reg_wdata", 32'(reg_wdata), 32'd0);
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_bus_active", 32'(bus_active), 32'd0);
    rst = 1'b0; fill = 1'b0;
    qtr();

    // Directed write and random read
    do_write(7'h50, 8'h10, 2, 24'hA53C00);
    do_read(1'b1, 8'h20, 2);

    // Foreign address, then our address with enable low: no response at all
    base_low = drove_low; base_busy = busy_seen;
    do_write(7'h51, 8'h00, 0, 24'h0);
    enable = 1'b0;
    do_write(7'h50, 8'h00, 1, 24'h000000);
    enable = 1'b1;
    check_eq("nomatch_sda_driven", 32'(drove_low - base_low), 32'd0);
    check_eq("nomatch_busy_seen", 32'(busy_seen - base_busy), 32'd0);

    // Pointer wrap
    do_write(7'h50, 8'hFF, 2, 24'h112200);

    // STOP after five bits of a data byte
    bus_start();
    send_byte(8'hA0, ack);
    check_eq("abort_addr_ack", 32'(ack), 32'd1);
    send_byte(8'h30, ack);
    check_eq("abort_ptr_ack", 32'(ack), 32'd1);
    ptr = 8'h30;
    abyte = 8'($urandom);
    for (int i = 0; i < 5; i++) clock_bit(abyte[7-i], s);
    bus_stop();
    check_eq("abort_sda_t", 32'(sda_t), 32'd1);
    check_eq("abort_busy", 32'(busy), 32'd0);
    check_eq("abort_bus_active", 32'(bus_active), 32'd0);
    check_queues("abort");
    do_write(7'h50, 8'h31, 2, {8'($urandom), 8'($urandom), 8'h00});

    // Reset while the target drives a 0 data bit
    bus_start();
    send_byte(8'hA0, ack);
    send_byte(8'h40, ack);
    bus_start();
    send_byte(8'hA1, ack);
    check_eq("prerst_addr_ack", 32'(ack), 32'd1);
    check_eq("prerst_sda_t_drive0", 32'(sda_t), 32'd0);
    exp_rd.push_back(8'h40);
    check_queues("prerst");
    rst = 1'b1;
    @(negedge clk);
    check_eq("midrst_sda_t", 32'(sda_t), 32'd1);
    check_eq("midrst_reg_addr", 32'(reg_addr), 32'd0);
    check_eq("midrst_reg_wdata", 32'(reg_wdata), 32'd0);
    check_eq("midrst_reg_rd", 32'(reg_rd), 32'd0);
    check_eq("midrst_reg_we", 32'(reg_we), 32'd0);
    check_eq("midrst_busy", 32'(busy), 32'd0);
    check_eq("midrst_bus_active", 32'(bus_active), 32'd0);
    rst = 1'b0;
    ptr = 8'h00;
    base_low = drove_low;
    abyte = 8'($urandom);
    for (int i = 0; i < 9; i++) clock_bit(abyte[i % 8], s);
    check_eq("postrst_sda_driven", 32'(drove_low - base_low), 32'd0);
    check_eq("postrst_busy", 32'(busy), 32'd0);
    check_queues("postrst");
    bus_stop();
    do_write(7'h50, 8'h05, 1, 24'h770000);
    do_read(1'b1, 8'h05, 1);

    // Randomised traffic against the transaction model
    for (int t = 0; t < 14; t++) begin
      case ($urandom_range(0, 3))
        0: do_write(7'h50, 8'($urandom), $urandom_range(1, 3), 24'($urandom));
        1: do_read(1'b1, 8'($urandom), $urandom_range(1, 3));
        2: do_read(1'b0, 8'h00, $urandom_range(1, 3));
        default: begin
          dev = 7'($urandom);
          if (dev == 7'h50) dev = 7'h51;
          do_write(dev, 8'($urandom), 1, 24'($urandom));
        end
      endcase
    end

    check_eq("we_rd_overlap", 32'(overlap), 32'd0);
    check_eq("sda_t_change_scl_high", 32'(hi_chg), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/i2c_slave_regs.md
Name: i2c_slave_regs

Overview:
- I2C target (responder) for the on-board management bus; it is the other end of the existing `i2c_master`.
- Exposes a byte-addressed register window to a host-side register interface, so board logic (SFP/PHY status, soft-reset control) is reachable from an external I2C controller.
- Open-drain SDA handling uses the same `_i/_o/_t` split as `i2c_master`. SCL is input-only; the block never stretches the clock.

Parameters:
DEV_ADDR, 7'h50, 7-bit I2C device address this target answers to
PTR_WIDTH, 8, register pointer width; pointer wraps modulo 2^PTR_WIDTH

Ports:
clk  input  1  system clock; must be at least 16x the SCL frequency
rst  input  1  synchronous, active-high reset
enable  input  1  0 = ignore all address bytes (always NACK)
scl_i  input  1  SCL pin sample
sda_i  input  1  SDA pin sample
sda_o  output  1  SDA drive value; constant 0
sda_t  output  1  SDA tristate; 1 = release, 0 = drive low
reg_addr  output  PTR_WIDTH  current register pointer
reg_wdata  output  8  write data; valid while reg_we=1
reg_we  output  1  one-cycle write strobe
reg_rd  output  1  one-cycle read strobe; reg_rdata is sampled in this same cycle
reg_rdata  input  8  read data for reg_addr; combinational from the host
busy  output  1  1 between an addressed START and the following STOP/NACK-idle
bus_active  output  1  1 between any START and STOP on the bus

Behaviour:
- Reset values: sda_t=1, sda_o=0, reg_we=0, reg_rd=0, reg_addr=0, reg_wdata=0, busy=0, bus_active=0, state=IDLE.
- Input conditioning:
  - scl_i and sda_i each pass through a 2-flop synchroniser, then one compare register.
  - Edge events are therefore seen 3 clk after the pin changes.
- Bus events:
  - START: SDA falls while SCL is high.
  - STOP: SDA rises while SCL is high.
  - SCL rise samples one data bit. SCL fall is the point where SDA outputs change.
- Bit order is MSB first. A 3-bit counter and an 8-bit shift register are shared by all byte states.
- States: IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK, WAIT.
- START from any state, including a repeated START mid-byte:
  - Go to ADDR, clear the bit counter, set sda_t=1.
  - Keep reg_addr unchanged.
  - Set bus_active=1.
- STOP from any state:
  - Go to IDLE, set sda_t=1, busy=0, bus_active=0.
  - A partial byte is discarded and produces no strobe.
- ADDR:
  - After the 8th SCL rise, compare byte[7:1] with DEV_ADDR; enable must be 1.
  - On match: at the next SCL fall set sda_t=0 and go to ADDR_ACK; set busy=1.
  - On mismatch: go to WAIT; sda_t stays 1.
- ADDR_ACK:
  - At the SCL fall that ends the ACK bit, branch on the R/W bit.
  - R/W=0: set sda_t=1 and go to PTR.
  - R/W=1: pulse reg_rd, latch reg_rdata into the shift register, drive bit 7 (sda_t = bit; 1 = release), go to RDATA.
- PTR:
  - After 8 bits, load the byte into reg_addr.
  - ACK through PTR_ACK (sda_t=0 for one SCL period), then go to WDATA.
- WDATA:
  - After 8 bits, set reg_wdata=byte and pulse reg_we for 1 clk with the current reg_addr, in the cycle after the 8th SCL rise.
  - ACK through WDATA_ACK; reg_addr increments when the ACK is driven.
  - Loop to WDATA.
- RDATA:
  - On each SCL fall, drive the next bit.
  - After the 8th bit is shifted out, release SDA at the next SCL fall and go to RDATA_ACK; reg_addr increments at that point.
- RDATA_ACK:
  - Sample SDA on the SCL rise.
  - ACK (0): at the SCL fall, pulse reg_rd, load the next byte, drive bit 7, go to RDATA.
  - NACK (1): go to WAIT with sda_t=1.
- WAIT: ignore everything until START or STOP.
- Pointer: increments modulo 2^PTR_WIDTH, so 0xFF goes to 0x00 for PTR_WIDTH=8. A write of the pointer byte alone (START, addr W, ptr, STOP) sets the pointer for a later read.
- SDA timing: sda_t changes only on SCL-fall events, never while SCL is high except on START/STOP release.
- reg_we and reg_rd never assert in the same cycle; each is exactly 1 clk per byte.
- rst mid-transfer: everything returns to reset values within 1 clk and SDA is released. The next transaction must begin with a START.

Test Plan:
- Write: START, 0xA0 (0x50 W), 0x10, 0xA5, 0x3C, STOP:
  - Three ACKs (sda_t=0 during each 9th clock).
  - reg_we pulses with (0x10, 0xA5) then (0x11, 0x3C).
  - busy=0 after STOP.
- Random read: START, 0xA0, 0x20, repeated START, 0xA1, host reg_rdata = 0x5A then 0xC3, master ACK then NACK, STOP:
  - SDA carries 0x5A then 0xC3.
  - reg_rd pulses at reg_addr 0x20 and 0x21.
  - Ends in IDLE.
- Address mismatch: START, 0xA2 (0x51), data 0x00:
  - sda_t stays 1 throughout.
  - No reg_we/reg_rd pulses; busy stays 0.
  - Repeat with DEV_ADDR matching but enable=0 and require the same result.
- Wrap: pointer 0xFF, write 0x11, 0x22 -> reg_we at 0xFF then 0x00.
- Abort: STOP after 5 bits of a data byte -> no reg_we pulse, state IDLE, sda_t=1.
  - A following full write succeeds normally.
- Reset mid-read while driving a 0 bit -> sda_t=1 next clk, all outputs at reset values, ignores SCL until the next START.
